// File: rtl/cic_pkg.sv
// Shared CIC definitions: configuration limits and register growth helper.
// Used by both the decimator and the interpolator.
package cic_pkg;

    localparam int unsigned MAX_STAGES = 6;
    localparam int unsigned MAX_RATE   = 64;

    // Bits gained by N integrators running over a decimation group of R samples
    function automatic int unsigned bit_growth(input int unsigned n, input int unsigned r);
        return n * $clog2(r);
    endfunction

endpackage

// File: rtl/cic_decim_if.sv
// Sample stream bundle for cic_decim: valid-qualified input and output, no backpressure.
// The master drives input samples; the filter (slave) drives decimated output.
interface cic_decim_if #(
    parameter int WIDTH = 8
);

    logic signed [WIDTH-1:0] i_in_data;
    logic                    i_in_valid;
    logic signed [WIDTH-1:0] o_out_data;
    logic                    o_out_valid;

    modport master (
        output i_in_data,
        output i_in_valid,
        input  o_out_data,
        input  o_out_valid
    );

    modport slave (
        input  i_in_data,
        input  i_in_valid,
        output o_out_data,
        output o_out_valid
    );

endinterface

// File: rtl/cic_comb_stage.sv
// One registered differentiator (M=1) of a CIC comb section.
// Advances only when its input valid is set; valid itself shifts every cycle.
module cic_comb_stage #(
    parameter int WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_delay;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_delay <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data  <= i_data - r_delay;
                r_delay <= i_data;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/cic_decim.sv
// CIC decimator: N wrapping integrators, decimate by RATE, N combs, top WIDTH bits out.
// Define CIC_DECIM_ROUND_EN for round-half-up output with +max saturation (one extra cycle).
module cic_decim
    import cic_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_STAGES = 3,
    parameter int RATE       = 4
) (
    input  logic      i_clock,
    input  logic      i_reset,
    cic_decim_if.slave io_stream
);

    localparam int ACC_WIDTH = WIDTH + int'(bit_growth(NUM_STAGES, RATE));
    localparam int GROWTH    = ACC_WIDTH - WIDTH;
    localparam int CNT_W     = $clog2(RATE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE - 1);

    if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES || RATE < 2 || RATE > MAX_RATE) begin : g_cfg_check
        $error("cic_decim: NUM_STAGES or RATE outside supported range");
    end

    logic [ACC_WIDTH-1:0] w_ext;
    logic [ACC_WIDTH-1:0] r_int [NUM_STAGES];
    logic [CNT_W-1:0]     r_count;
    logic                 r_dec_stb;
    logic                 r_dec_valid;
    logic [ACC_WIDTH-1:0] r_dec_data;

    assign w_ext = {{GROWTH{io_stream.i_in_data[WIDTH-1]}}, io_stream.i_in_data};

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                r_int[k] <= '0;
            end
        end else if (io_stream.i_in_valid) begin
            r_int[0] <= r_int[0] + w_ext;
            for (int unsigned k = 1; k < NUM_STAGES; k++) begin
                r_int[k] <= r_int[k] + r_int[k-1];
            end
        end
    end

    // The strobe marks the group's last edge; the following edge captures the
    // settled last integrator, which is what the comb chain then sees.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_count     <= '0;
            r_dec_stb   <= 1'b0;
            r_dec_valid <= 1'b0;
            r_dec_data  <= '0;
        end else begin
            r_dec_stb   <= io_stream.i_in_valid && (r_count == CNT_LAST);
            r_dec_valid <= r_dec_stb;
            if (r_dec_stb) begin
                r_dec_data <= r_int[NUM_STAGES-1];
            end
            if (io_stream.i_in_valid) begin
                r_count <= (r_count == CNT_LAST) ? '0 : r_count + CNT_W'(1);
            end
        end
    end

    logic [ACC_WIDTH-1:0] w_comb_data [NUM_STAGES+1];
    logic [NUM_STAGES:0]  w_comb_valid;

    assign w_comb_data[0]  = r_dec_data;
    assign w_comb_valid[0] = r_dec_valid;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_comb
        cic_comb_stage #(
            .WIDTH(ACC_WIDTH)
        ) u_comb (
            .i_clock(i_clock),
            .i_reset(i_reset),
            .i_data (w_comb_data[g]),
            .i_valid(w_comb_valid[g]),
            .o_data (w_comb_data[g+1]),
            .o_valid(w_comb_valid[g+1])
        );
    end

    logic [ACC_WIDTH-1:0] w_last;
    logic                 w_last_valid;
    logic [WIDTH-1:0]     w_stage_data;
    logic                 w_stage_valid;
    logic                 w_unused_lsbs;

    assign w_last       = w_comb_data[NUM_STAGES];
    assign w_last_valid = w_comb_valid[NUM_STAGES];

`ifdef CIC_DECIM_ROUND_EN
    localparam logic [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (GROWTH - 1);

    logic [ACC_WIDTH:0] w_sum;
    logic               w_sat;
    logic [WIDTH-1:0]   w_rounded;
    logic [WIDTH-1:0]   r_rnd_data;
    logic               r_rnd_valid;

    // Adding a positive half-LSB can only overflow upwards, so only +max saturation exists
    assign w_sum         = {w_last[ACC_WIDTH-1], w_last} + HALF;
    assign w_sat         = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    assign w_rounded     = w_sat ? {1'b0, {(WIDTH-1){1'b1}}} : w_sum[ACC_WIDTH-1 -: WIDTH];
    assign w_unused_lsbs = ^w_sum[GROWTH-1:0];

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_rnd_data  <= '0;
            r_rnd_valid <= 1'b0;
        end else begin
            r_rnd_valid <= w_last_valid;
            if (w_last_valid) begin
                r_rnd_data <= w_rounded;
            end
        end
    end

    assign w_stage_data  = r_rnd_data;
    assign w_stage_valid = r_rnd_valid;
`else
    assign w_stage_data  = w_last[ACC_WIDTH-1 -: WIDTH];
    assign w_stage_valid = w_last_valid;
    assign w_unused_lsbs = ^w_last[GROWTH-1:0];
`endif

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_stage_valid;
            if (w_stage_valid) begin
                r_out_data <= w_stage_data;
            end
        end
    end

    assign io_stream.o_out_data  = r_out_data;
    assign io_stream.o_out_valid = r_out_valid;

endmodule

// File: tb/tb_cic_decim.sv
// Bench for cic_decim (WIDTH=8, N=3, R=4): equivalent-FIR model with timing scoreboard
// plus literal expectations for impulse, DC and mid-group reset cases.
module tb_cic_decim;

    localparam int W   = 8;
    localparam int N   = 3;
    localparam int R   = 4;
    localparam int G   = N * $clog2(R);
    localparam int ACC = W + G;
`ifdef CIC_DECIM_ROUND_EN
    localparam int LAT = N + 3;
`else
    localparam int LAT = N + 2;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cic_decim_if #(.WIDTH(W)) bus ();

    cic_decim #(
        .WIDTH     (W),
        .NUM_STAGES(N),
        .RATE      (R)
    ) dut (
        .i_clock  (clk),
        .i_reset  (rst_n),
        .io_stream(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Equivalent FIR: impulse response is N cascaded length-R boxcars; the
    // registered integrator chain adds a pure delay of N-1 accepted samples.
    longint h[];
    int     hist[$];
    int     obs[$];
    int     ref_obs[$];
    typedef struct {
        longint due;
        int     data;
    } exp_t;
    exp_t   exp_q[$];
    longint cyc       = 0;
    int     last_data = 0;

    function automatic void build_h();
        longint t[];
        h    = new[1];
        h[0] = 1;
        for (int s = 0; s < N; s++) begin
            t = new[h.size() + R - 1];
            foreach (t[i]) t[i] = 0;
            for (int i = 0; i < h.size(); i++)
                for (int j = 0; j < R; j++)
                    t[i+j] += h[i];
            h = t;
        end
    endfunction

    function automatic int predict();
        longint v = 0;
        int     n = hist.size() - 1;
        for (int j = 0; j < h.size(); j++) begin
            int idx = n - (N - 1) - j;
            if (idx >= 0) v += h[j] * hist[idx];
        end
        v = (v <<< (64 - ACC)) >>> (64 - ACC);
`ifdef CIC_DECIM_ROUND_EN
        v = (v + (longint'(1) <<< (G - 1))) >>> G;
        if (v > (2 ** (W - 1)) - 1) v = (2 ** (W - 1)) - 1;
`else
        v = v >>> G;
`endif
        return int'(v);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            hist.delete();
            exp_q.delete();
            last_data = 0;
        end else if (bus.i_in_valid) begin
            hist.push_back(int'(bus.i_in_data));
            if (hist.size() % R == 0) exp_q.push_back('{cyc + LAT, predict()});
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("out_valid_due", longint'(bus.o_out_valid), 1);
            chk("out_data", longint'(bus.o_out_data), longint'(exp_q[0].data));
            last_data = exp_q[0].data;
            void'(exp_q.pop_front());
        end else begin
            chk("out_valid_idle", longint'(bus.o_out_valid), 0);
            chk("out_data_hold", longint'(bus.o_out_data), longint'(last_data));
        end
        if (bus.o_out_valid) obs.push_back(int'(bus.o_out_data));
    end

    task automatic step(input logic r, input logic v, input int d);
        @(negedge clk);
        rst_n          = r;
        bus.i_in_valid = v;
        bus.i_in_data  = W'(d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 0);
    endtask

    task automatic check_list(input string name, input int exp[$]);
        chk({name, "_count"}, obs.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs.size(); i++)
            chk(name, longint'(obs[i]), longint'(exp[i]));
    endtask

    initial begin
        int acc;
        bus.i_in_valid = 1'b0;
        bus.i_in_data  = '0;
        build_h();

        repeat (3) step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        @(posedge clk); #1;
        chk("reset_valid", longint'(bus.o_out_valid), 0);
        chk("reset_data", longint'(bus.o_out_data), 0);

        // DC 100, gapless
        obs.delete();
        repeat (40) step(1'b1, 1'b1, 100);
        idle(LAT + 4);
        ref_obs = obs;
        chk("dc100_count", obs.size(), 10);
        chk("dc100_steady", longint'(obs[obs.size()-1]), 100);

        // DC extremes, integrators wrap freely
        repeat (40) step(1'b1, 1'b1, -128);
        idle(LAT + 4);
        chk("dc_neg128_steady", longint'(obs[obs.size()-1]), -128);
        repeat (40) step(1'b1, 1'b1, 127);
        idle(LAT + 4);
        chk("dc_pos127_steady", longint'(obs[obs.size()-1]), 127);

        // DC 100 at ~30% input duty must reproduce the gapless sequence
        step(1'b0, 1'b0, 0);
        obs.delete();
        acc = 0;
        for (int c = 0; c < 4000 && acc < 40; c++) begin
            if ($urandom_range(99) < 30) begin
                step(1'b1, 1'b1, 100);
                acc++;
            end else begin
                step(1'b1, 1'b0, 0);
            end
        end
        idle(LAT + 4);
        check_list("gap_vs_gapless", ref_obs);

        // Impulse 64: outputs 3, 12, 1, 0 (phase sums 192/768/64 over 2^6)
        step(1'b0, 1'b0, 0);
        obs.delete();
        step(1'b1, 1'b1, 64);
        repeat (15) step(1'b1, 1'b1, 0);
        idle(LAT + 4);
        check_list("impulse64", '{3, 12, 1, 0});

        // Impulse 32: 1.5, 6, 0.5, 0 before quantisation
        step(1'b0, 1'b0, 0);
        obs.delete();
        step(1'b1, 1'b1, 32);
        repeat (15) step(1'b1, 1'b1, 0);
        idle(LAT + 4);
`ifdef CIC_DECIM_ROUND_EN
        check_list("impulse32", '{2, 6, 1, 0});
`else
        check_list("impulse32", '{1, 6, 0, 0});
`endif

        // Reset two inputs into a group
        step(1'b0, 1'b0, 0);
        repeat (8) step(1'b1, 1'b1, 50);
        idle(LAT + 4);
        repeat (2) step(1'b1, 1'b1, 50);
        step(1'b0, 1'b0, 0);
        @(posedge clk); #1;
        chk("midreset_valid", longint'(bus.o_out_valid), 0);
        chk("midreset_data", longint'(bus.o_out_data), 0);
        obs.delete();
        repeat (4) step(1'b1, 1'b1, 50);
        idle(LAT + 4);
        check_list("after_midreset", '{3});

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cic_decim.md
Name: cic_decim

Overview:
- CIC decimation filter: N integrators at the input rate, decimation by R, then N combs at the output rate (differential delay M=1).
- Receive-side counterpart of cic_interp; sits between ADC/front-end sample streams and downstream DSP.
- Valid-qualified streaming with no backpressure. Full-precision internal arithmetic; output is the top WIDTH bits.

Parameters:
- WIDTH, 8, input and output sample width, two's complement.
- NUM_STAGES, 3, number of integrator stages and comb stages (N), 1..6.
- RATE, 4, decimation ratio R, 2..64.
- ACC_WIDTH, WIDTH + NUM_STAGES*$clog2(RATE), internal width (derived localparam, not overridable).

Ports:
- i_clock  input  1  single clock; all logic on its rising edge.
- i_reset  input  1  synchronous, active-low reset (0 = reset).
- i_in_data  input  WIDTH  signed input sample.
- i_in_valid  input  1  input sample strobe; any duty cycle, gaps allowed.
- o_out_data  output  WIDTH  signed decimated sample.
- o_out_valid  output  1  one-cycle strobe, at most once per RATE accepted inputs.

Behaviour:
- Reset (i_reset==0 at a clock edge): all integrators, comb registers, comb delay registers, decimation counter, pipeline valids, o_out_data and o_out_valid are cleared to 0. Reset takes priority over i_in_valid.
- Input extension: i_in_data is sign-extended to ACC_WIDTH.
- Integrators: on each cycle with i_in_valid=1:
  - int[0] <= int[0] + ext(in).
  - int[k] <= int[k] + int[k-1] (registered previous-stage value), k=1..N-1.
  - Integrators hold when i_in_valid=0.
  - Modular (wrapping) add; overflow is intentional and correct for CIC.
- Decimation counter:
  - Range 0..RATE-1; increments on each i_in_valid; wraps RATE-1 -> 0.
  - When count==RATE-1 and i_in_valid=1: next cycle, dec_valid=1 and dec_data = int[N-1] (value after that edge's update).
- Comb pipeline, one register per stage, advanced only by its stage valid:
  - c[k] <= x[k] - d[k]; d[k] <= x[k], where x[0]=dec_data and x[k]=c[k-1].
  - Valid shifts one stage per cycle; comb stages hold when their input valid is 0.
- Output:
  - o_out_data <= c[N-1][ACC_WIDTH-1 -: WIDTH] (truncation) when the last comb valid is 1; otherwise it holds its previous value.
  - o_out_valid <= last comb valid.
- Latency: o_out_valid asserts exactly N+2 cycles after the edge that accepts the RATE-th input of a group. It is independent of input gaps.
- Throughput: one input per cycle sustained. Decimated samples are spaced >= RATE cycles, so the comb pipeline never overlaps in an illegal way.
- DC gain: RATE^N = 2^(N*clog2(RATE)) when RATE is a power of two, so unity gain after truncation. For non-power-of-two RATE, gain is RATE^N / 2^(ACC_WIDTH-WIDTH), which is less than 1 and is documented, not corrected.
- Reset mid-operation: partial decimation group discarded; counter restarts at 0; first output comes after RATE new inputs plus latency. Transient filter history restarts from zero state.

Optional Feature:
- Macro CIC_DECIM_ROUND_EN.
- Defined: output rounds half-up. Add 2^(ACC_WIDTH-WIDTH-1) to c[N-1] before slicing, saturating at +max. This adds one cycle of latency (N+3 total).
- Undefined: plain truncation, latency N+2.

Decomposition:
- Package cic_pkg, shared with cic_interp: function clog2-based growth (bit_growth(N,R)), localparam limits MAX_STAGES=6 and MAX_RATE=64.
- Sub-module cic_comb_stage (WIDTH param): one registered differentiator with valid in/out, instantiated N times in a generate loop.
- Integrators stay inline.

Test Plan:
- WIDTH=8, N=3, R=4; DC 100 on every cycle -> after settling (>=3 outputs), o_out_data=100 steady; one valid every 4 cycles.
- Same config; DC -128 and then DC +127 -> steady outputs -128 and 127. Integrator wrap is exercised, no output error.
- Same DC 100 with i_in_valid random 30% duty -> output sequence identical to the gapless run. Each o_out_valid comes exactly 5 cycles after the 4th accepted input.
- Impulse 64 at sample 0, zeros after -> decimated outputs match the golden model (polyphase sum 16 before truncation, 0-filled after settling). Bit-exact against a C/Python reference model.
- Assert i_reset=0 for 1 cycle after 2 inputs of a group -> all outputs 0 and o_out_valid=0 the next cycle. The next o_out_valid comes after 4 fresh inputs + 5 cycles.
- CIC_DECIM_ROUND_EN defined; the golden model value ending in .5 LSB rounds up, 127.5 saturates to 127; latency 6.
